sm_uart_loader: RTL and testbench
=================================

// Module: sm_uart_loader
// PURPOSE
//  Bus initiator that drives the memory matrix user port (userAddr/userWe/userWData) from a UART byte stream.
//  Downloads a program/data image into RAM while the CPU is held off via 'loading'.
//  Sits beside the CPU in the top level; the matrix is the responder, this block is the writer.
// PARAMETERS
//  BAUD_DIV     434       clk cycles per UART bit (50 MHz / 115200); must be >= 4
//  TIMEOUT      2_000_000 idle clk cycles mid-session before abort
// PORTS
//  clk          in   1    system clock; everything rising-edge
//  rst_n        in   1    asynchronous active-low reset
//  rx           in   1    UART RX line, idle high, 8N1, LSB first; asynchronous to clk
//  userAddr     out  32   byte address to matrix user port
//  userWe       out  1    one-cycle write strobe to matrix user port
//  userWData    out  32   write data to matrix user port
//  loading      out  1    high from valid sync byte to session end; holds CPU in reset
//  done         out  1    one-cycle pulse on successful session completion
//  err          out  1    sticky: framing error or timeout; cleared by next valid sync byte
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; counters and assembly register 0.
//  Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
//  RX: rx passes a 2-FF synchronizer; start detected on synced falling edge.
//   Start bit re-checked at BAUD_DIV/2; if high -> false start, return to line idle.
//   Data sampled every BAUD_DIV from mid-start; stop sampled likewise.
//   Stop=1 -> byte_valid pulse; stop=0 -> frame_err pulse, no byte.
//  Frame: SYNC(0xA5) | ADDR[4] LE | COUNT[2] LE | DATA[4*COUNT], words LE (first byte -> [7:0]).
//  FSM states: IDLE -> ADDR -> CNT -> DATA -> IDLE.
//   IDLE: byte==SYNC -> ADDR, loading=1, err=0, byte idx=0; other bytes ignored; frame_err ignored.
//   ADDR: 4 bytes into base; then -> CNT.
//   CNT: 2 bytes into count; count==0 -> done pulse, loading=0, IDLE; else -> DATA.
//   DATA: bytes shift into word. On 4th byte: userWData=word, userAddr=base+4*k, userWe=1 for exactly
//    1 cycle (cycle after byte_valid); k++.
//    After write with k==count: done pulse coincident with the following cycle; loading=0; IDLE.
//  userAddr/userWData hold their last value when userWe=0. Address wraps mod 2^32; no alignment check,
//   but [1:0] of base is forced to 0.
//  Abort: in ADDR/CNT/DATA, frame_err or TIMEOUT cycles with no byte_valid -> err=1, loading=0, IDLE;
//   partial word discarded; writes already issued stay.
//  Timeout counter resets on every byte_valid and on leaving IDLE; inactive in IDLE.
//  SYNC byte inside ADDR/CNT/DATA is plain data (no resync).
//  rst_n asserted mid-session: immediate return to reset values; no further write strobe.
//  No backpressure: matrix user port accepts a write every cycle; the write rate is bounded by UART
//   (1 word per 40*BAUD_DIV).
// STRUCTURE
//  sm_config.vh: `SM_LOADER_SYNC 8'hA5; FSM state encodings `SM_LD_IDLE/ADDR/CNT/DATA.
//  Sub-module sm_uart_rx (clk, rst_n, rx, byte_valid, byte_data[7:0], frame_err) with BAUD_DIV parameter:
//   synchronizer + bit timer + shift register.
//  Top: session FSM, byte index, word counter, timeout counter, output registers.
// TESTING (BAUD_DIV=8, TIMEOUT=400)
//  1. Send A5, 00 10 00 00, 02 00, 78 56 34 12, EF BE AD DE -> userWe pulses:
//     (0x1000, 0x12345678), (0x1004, 0xDEADBEEF); done=1 once; loading 0 afterwards; err=0.
//  2. Send 33 then A5, 00 00 00 00, 00 00 -> 0x33 ignored; no userWe; done pulse; loading high only
//     between sync and count.
//  3. Send A5, header for 2 words, 1 word, then idle 400 cycles -> one write at base; err=1, loading=0,
//     no done.
//  4. Send A5, header, bytes with one stop bit driven 0 -> err=1, IDLE; a new valid session clears err
//     and writes normally.
//  5. rx glitch low for 2 cycles (< BAUD_DIV/2) -> no byte_valid, FSM stays IDLE.
//  6. Assert rst_n low during 3rd data byte of word 0 -> all outputs 0 immediately; no userWe after
//     release until a new sync.

Source files
------------

// File: rtl/sm_uart_loader_pkg.sv
// rtl/sm_uart_loader_pkg.sv - shared types and constants for the UART image loader
package sm_uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_ADDR = 2'd1,
        LD_CNT  = 2'd2,
        LD_DATA = 2'd3
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Word k of a session lands at the word-aligned base plus 4*k, wrapping mod 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] k);
        return {base[31:2], 2'b00} + {14'd0, k, 2'b00};
    endfunction

endpackage

// File: rtl/sm_uart_loader_if.sv
// rtl/sm_uart_loader_if.sv - matrix user-port write bus plus loader status
interface sm_uart_loader_if;
    logic [31:0] userAddr;
    logic        userWe;
    logic [31:0] userWData;
    logic        loading;
    logic        done;
    logic        err;

    modport master (
        output userAddr, userWe, userWData, loading, done, err
    );

    modport slave (
        input userAddr, userWe, userWData, loading, done, err
    );
endinterface

// File: rtl/sm_uart_rx.sv
// rtl/sm_uart_rx.sv - 8N1 UART receiver: synchronizer, mid-bit timer, shift register
module sm_uart_rx
    import sm_uart_loader_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronizer flops reset to the idle-high line level so reset release is not a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sm_uart_loader.sv
// rtl/sm_uart_loader.sv - UART-driven session FSM writing an image into the memory matrix
module sm_uart_loader
    import sm_uart_loader_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int TIMEOUT  = 2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    sm_uart_loader_if.master  bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;

    ld_state_t   state;
    logic [1:0]  idx;
    logic [31:0] base;
    logic [15:0] count;
    logic [15:0] k;
    logic [31:0] word;
    logic [TW-1:0] tmo;
    logic        abort;

    logic [31:0] user_addr;
    logic        user_we;
    logic [31:0] user_wdata;
    logic        loading;
    logic        done;
    logic        err;

    sm_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign abort = (state != LD_IDLE) &&
                   (frame_err || (!byte_valid && tmo == TMO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LD_IDLE;
            idx        <= '0;
            base       <= '0;
            count      <= '0;
            k          <= '0;
            word       <= '0;
            tmo        <= '0;
            user_addr  <= '0;
            user_we    <= 1'b0;
            user_wdata <= '0;
            loading    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            user_we <= 1'b0;
            done    <= 1'b0;
            if (state == LD_IDLE || byte_valid) tmo <= '0;
            else                                tmo <= tmo + 1'b1;

            if (abort) begin
                err     <= 1'b1;
                loading <= 1'b0;
                state   <= LD_IDLE;
            end else begin
                unique case (state)
                    LD_IDLE: begin
                        if (byte_valid && byte_data == SYNC_BYTE) begin
                            state   <= LD_ADDR;
                            loading <= 1'b1;
                            err     <= 1'b0;
                            idx     <= '0;
                            k       <= '0;
                        end
                    end
                    LD_ADDR: begin
                        if (byte_valid) begin
                            base <= {byte_data, base[31:8]};
                            idx  <= idx + 2'd1;
                            if (idx == 2'd3) state <= LD_CNT;
                        end
                    end
                    LD_CNT: begin
                        if (byte_valid) begin
                            count <= {byte_data, count[15:8]};
                            idx   <= idx + 2'd1;
                            if (idx == 2'd1) begin
                                idx <= '0;
                                if ({byte_data, count[15:8]} == 16'd0) begin
                                    done    <= 1'b1;
                                    loading <= 1'b0;
                                    state   <= LD_IDLE;
                                end else begin
                                    state <= LD_DATA;
                                end
                            end
                        end
                    end
                    LD_DATA: begin
                        // Session ends in the cycle after the final strobe so done trails userWe by one.
                        if (user_we && k == count) begin
                            done    <= 1'b1;
                            loading <= 1'b0;
                            state   <= LD_IDLE;
                        end else if (byte_valid) begin
                            word <= {byte_data, word[31:8]};
                            idx  <= idx + 2'd1;
                            if (idx == 2'd3) begin
                                user_wdata <= {byte_data, word[31:8]};
                                user_addr  <= word_addr(base, k);
                                user_we    <= 1'b1;
                                k          <= k + 16'd1;
                            end
                        end
                    end
                    default: state <= LD_IDLE;
                endcase
            end
        end
    end

    assign bus.userAddr  = user_addr;
    assign bus.userWe    = user_we;
    assign bus.userWData = user_wdata;
    assign bus.loading   = loading;
    assign bus.done      = done;
    assign bus.err       = err;

endmodule

// File: tb/tb_sm_uart_loader.sv
// tb/tb_sm_uart_loader.sv - randomized self-checking bench for sm_uart_loader
module tb_sm_uart_loader;

    localparam int BAUD_DIV = 8;
    localparam int TIMEOUT  = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    always #5 clk = ~clk;

    sm_uart_loader_if bus();

    sm_uart_loader #(.BAUD_DIV(BAUD_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int byte_cnt = 0;
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  frame[$];
    logic [31:0] words_q[$];

    always @(negedge clk) begin
        if (bus.userWe) wr_q.push_back({bus.userAddr, bus.userWData});
        if (bus.done) done_cnt++;
        if (dut.u_rx.byte_valid) byte_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        @(negedge clk);
        rx = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        rx = stop;
        repeat (BAUD_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Reference: frame bytes and expected writes follow directly from the session format.
    task automatic build_session(input logic [31:0] base);
        logic [15:0] n;
        logic [31:0] w;
        frame.delete();
        exp_q.delete();
        n = 16'(words_q.size());
        frame.push_back(8'hA5);
        for (int i = 0; i < 4; i++) frame.push_back(base[8*i +: 8]);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int j = 0; j < words_q.size(); j++) begin
            w = words_q[j];
            for (int i = 0; i < 4; i++) frame.push_back(w[8*i +: 8]);
            exp_q.push_back({(base & 32'hFFFF_FFFC) + 32'(4 * j), w});
        end
    endtask

    task automatic send_frame(input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(frame[i], 1'b1, $urandom_range(4, 20));
    endtask

    task automatic run_and_check(input string tag);
        int d0;
        wr_q.delete();
        d0 = done_cnt;
        send_frame(0, frame.size() - 1);
        repeat (10) @(negedge clk);
        check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        if (wr_q.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_loading"}, 64'(bus.loading), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
    endtask

    initial begin
        int d0;
        int b0;
        int t;
        logic [31:0] base;

        #1;
        check("rst_addr", 64'(bus.userAddr), 64'd0);
        check("rst_we", 64'(bus.userWe), 64'd0);
        check("rst_wdata", 64'(bus.userWData), 64'd0);
        check("rst_flags", {61'd0, bus.loading, bus.done, bus.err}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        words_q = '{32'h1234_5678, 32'hDEAD_BEEF};
        build_session(32'h0000_1000);
        run_and_check("basic");

        wr_q.delete();
        d0 = done_cnt;
        send_byte(8'h33, 1'b1, 6);
        check("ign_loading", 64'(bus.loading), 64'd0);
        send_byte(8'hA5, 1'b1, 6);
        check("sync_loading", 64'(bus.loading), 64'd1);
        for (int i = 0; i < 6; i++) send_byte(8'h00, 1'b1, 6);
        repeat (5) @(negedge clk);
        check("zero_nwr", 64'(wr_q.size()), 64'd0);
        check("zero_done", 64'(done_cnt - d0), 64'd1);
        check("zero_loading", 64'(bus.loading), 64'd0);

        words_q = '{32'hCAFE_0001, 32'hCAFE_0002};
        build_session(32'h0000_2000);
        wr_q.delete();
        d0 = done_cnt;
        send_frame(0, 10);
        t = 0;
        while (!bus.err && t < 2 * TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        check("tmo_err", 64'(bus.err), 64'd1);
        check("tmo_loading", 64'(bus.loading), 64'd0);
        check("tmo_done", 64'(done_cnt - d0), 64'd0);
        check("tmo_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() == 1) check("tmo_wr0", wr_q[0], exp_q[0]);

        words_q = '{32'h1111_2222, 32'h3333_4444};
        build_session(32'h0000_3000);
        wr_q.delete();
        send_frame(0, 8);
        send_byte(frame[9], 1'b0, 8);
        repeat (10) @(negedge clk);
        check("ferr_err", 64'(bus.err), 64'd1);
        check("ferr_loading", 64'(bus.loading), 64'd0);
        check("ferr_nwr", 64'(wr_q.size()), 64'd0);
        words_q = '{32'h5555_6666};
        build_session(32'h0000_3100);
        run_and_check("recover");

        wr_q.delete();
        b0 = byte_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_bytes", 64'(byte_cnt - b0), 64'd0);
        check("glitch_loading", 64'(bus.loading), 64'd0);

        words_q = '{32'h7777_8888};
        build_session(32'h0000_4000);
        wr_q.delete();
        d0 = done_cnt;
        send_frame(0, 8);
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * BAUD_DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", 64'(bus.userAddr), 64'd0);
        check("mid_rst_wdata", 64'(bus.userWData), 64'd0);
        check("mid_rst_flags", {60'd0, bus.userWe, bus.loading, bus.done, bus.err}, 64'd0);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h88, 1'b1, 6);
        send_byte(8'h77, 1'b1, 6);
        repeat (10) @(negedge clk);
        check("post_rst_nwr", 64'(wr_q.size()), 64'd0);
        check("post_rst_loading", 64'(bus.loading), 64'd0);
        check("post_rst_done", 64'(done_cnt - d0), 64'd0);

        for (int n = 0; n < 6; n++) begin
            base = $urandom;
            if (n == 4) base = 32'hFFFF_FFFE;
            words_q.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) words_q.push_back($urandom);
            if (n == 5) words_q.push_back(32'hA5A5_A5A5);
            build_session(base);
            run_and_check($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
